// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
//   Shares one cacheline adaptor between NUM_PORTS cache ports. A winner is
//   chosen in IDLE (fixed priority or round-robin), its address / write line /
//   op are captured, and the adaptor request is held in BUSY until mem_resp.
//   A one-cycle DONE state gives the requester time to drop its request
//   before the next arbitration.
//
// Parameters
//   NUM_PORTS  number of requesting ports (2..8)
//   LINE_W     cache line width in bits
//   ARB_MODE   0 = fixed priority (port 0 highest), 1 = round-robin
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_read / req_write    per-port level requests, held until req_resp
//   req_addr / req_wdata    per-port address and write line, packed by port
//   req_rdata               read line, broadcast to all ports
//   req_resp                per-port one-cycle completion pulse
//   mem_read / mem_write    adaptor request (exactly one high in BUSY)
//   mem_address / mem_wdata registered address and write line to adaptor
//   mem_rdata / mem_resp    adaptor read line and completion pulse
//   grant                   one-hot owner during BUSY, zero otherwise
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int ARB_MODE  = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_read,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*32-1:0]       req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0]   req_wdata,
    output logic [LINE_W-1:0]             req_rdata,
    output logic [NUM_PORTS-1:0]          req_resp,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [31:0]                   mem_address,
    output logic [LINE_W-1:0]             mem_wdata,
    input  logic [LINE_W-1:0]             mem_rdata,
    input  logic                          mem_resp,
    output logic [NUM_PORTS-1:0]          grant
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [IDX_W-1:0]      r_winner;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic                  r_op_write;
    logic [31:0]           r_addr;
    logic [LINE_W-1:0]     r_wdata;

    logic [NUM_PORTS-1:0]  w_pending;
    logic                  w_any_pending;
    logic [IDX_W-1:0]      w_probe;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_sel_found;
    logic                  w_sel_write;
    logic [31:0]           w_sel_addr;
    logic [LINE_W-1:0]     w_sel_wdata;
    logic [NUM_PORTS-1:0]  w_winner_oh;
    logic                  w_busy;
    logic                  w_done_txn;

    assign w_pending     = req_read | req_write;
    assign w_any_pending = |w_pending;

    // Winner search. In round-robin mode the probe order starts at rr_ptr and
    // wraps; in fixed mode it simply counts up from port 0.
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves a variable unassigned, which would infer a latch.
    always_comb begin
        w_probe     = '0;
        w_sel_idx   = '0;
        w_sel_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == 0) begin
                w_probe = IDX_W'(k);
            end else begin
                w_probe = IDX_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
            end
            if (!w_sel_found && w_pending[w_probe]) begin
                w_sel_idx   = w_probe;
                w_sel_found = 1'b1;
            end
        end
    end

    // Mux the winner's request fields with constant slice offsets.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                // A port raising both read and write is treated as a write.
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*32 +: 32];
                w_sel_wdata = req_wdata[i*LINE_W +: LINE_W];
            end
        end
    end

    always_comb begin
        w_winner_oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_winner_oh[i] = (r_winner == IDX_W'(i));
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and FSM-driven outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done_txn  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_pending) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_busy = 1'b1;
                if (mem_resp) begin
                    w_done_txn  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Captured transaction and round-robin pointer. The pointer only moves when
    // a transaction completes, so an aborted (reset) transaction leaves no trace.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_winner   <= '0;
            r_rr_ptr   <= '0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            if (r_state == IDLE && w_any_pending) begin
                r_winner   <= w_sel_idx;
                r_op_write <= w_sel_write;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
            end
            if (ARB_MODE != 0 && w_done_txn) begin
                if (r_winner == IDX_W'(NUM_PORTS - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= r_winner + IDX_W'(1);
                end
            end
        end
    end

    assign mem_read    = w_busy && !r_op_write;
    assign mem_write   = w_busy &&  r_op_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign grant       = w_busy ? w_winner_oh : '0;
    assign req_resp    = w_done_txn ? w_winner_oh : '0;
    assign req_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_rr
//   Three arbiter instances (2-port round-robin, 2-port fixed, 4-port
//   round-robin) share one stimulus set; `sel` routes requests and mem_resp to
//   the instance under test and muxes its outputs onto obs_* signals.
//   Expected transactions are queued when requests are raised and popped as
//   the arbiter issues them to the adaptor.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_rr;

    localparam int LINE_W = 256;

    typedef struct {
        int                port;
        logic              wr;
        logic [31:0]       addr;
        logic [LINE_W-1:0] wdata;
    } txn_t;

    logic clk;
    logic reset_n;

    logic [3:0]          s_read;
    logic [3:0]          s_write;
    logic [127:0]        s_addr;
    logic [4*LINE_W-1:0] s_wdata;
    logic                s_mem_resp;
    logic [LINE_W-1:0]   s_mem_rdata;
    int                  sel;

    txn_t sb[$];
    int   vectors;
    int   miscompares;

    // Per-instance outputs
    logic [LINE_W-1:0] a_rdata, b_rdata, c_rdata;
    logic [1:0]        a_resp, b_resp, a_grant, b_grant;
    logic [3:0]        c_resp, c_grant;
    logic              a_mrd, a_mwr, b_mrd, b_mwr, c_mrd, c_mwr;
    logic [31:0]       a_addr, b_addr, c_addr;
    logic [LINE_W-1:0] a_wd, b_wd, c_wd;

    // Observed outputs of the selected instance
    logic [LINE_W-1:0] obs_rdata;
    logic [3:0]        obs_resp;
    logic [3:0]        obs_grant;
    logic              obs_mem_read;
    logic              obs_mem_write;
    logic [31:0]       obs_addr;
    logic [LINE_W-1:0] obs_wdata;

    mem_arbiter_rr #(.NUM_PORTS(2), .LINE_W(LINE_W), .ARB_MODE(1)) u_rr2 (
        .clk(clk), .reset_n(reset_n),
        .req_read(sel == 0 ? s_read[1:0] : 2'b00),
        .req_write(sel == 0 ? s_write[1:0] : 2'b00),
        .req_addr(s_addr[63:0]), .req_wdata(s_wdata[2*LINE_W-1:0]),
        .req_rdata(a_rdata), .req_resp(a_resp),
        .mem_read(a_mrd), .mem_write(a_mwr), .mem_address(a_addr), .mem_wdata(a_wd),
        .mem_rdata(s_mem_rdata), .mem_resp(sel == 0 && s_mem_resp), .grant(a_grant)
    );

    mem_arbiter_rr #(.NUM_PORTS(2), .LINE_W(LINE_W), .ARB_MODE(0)) u_fp2 (
        .clk(clk), .reset_n(reset_n),
        .req_read(sel == 1 ? s_read[1:0] : 2'b00),
        .req_write(sel == 1 ? s_write[1:0] : 2'b00),
        .req_addr(s_addr[63:0]), .req_wdata(s_wdata[2*LINE_W-1:0]),
        .req_rdata(b_rdata), .req_resp(b_resp),
        .mem_read(b_mrd), .mem_write(b_mwr), .mem_address(b_addr), .mem_wdata(b_wd),
        .mem_rdata(s_mem_rdata), .mem_resp(sel == 1 && s_mem_resp), .grant(b_grant)
    );

    mem_arbiter_rr #(.NUM_PORTS(4), .LINE_W(LINE_W), .ARB_MODE(1)) u_rr4 (
        .clk(clk), .reset_n(reset_n),
        .req_read(sel == 2 ? s_read : 4'b0000),
        .req_write(sel == 2 ? s_write : 4'b0000),
        .req_addr(s_addr), .req_wdata(s_wdata),
        .req_rdata(c_rdata), .req_resp(c_resp),
        .mem_read(c_mrd), .mem_write(c_mwr), .mem_address(c_addr), .mem_wdata(c_wd),
        .mem_rdata(s_mem_rdata), .mem_resp(sel == 2 && s_mem_resp), .grant(c_grant)
    );

    always_comb begin
        obs_rdata = a_rdata; obs_resp = {2'b00, a_resp}; obs_grant = {2'b00, a_grant};
        obs_mem_read = a_mrd; obs_mem_write = a_mwr; obs_addr = a_addr; obs_wdata = a_wd;
        if (sel == 1) begin
            obs_rdata = b_rdata; obs_resp = {2'b00, b_resp}; obs_grant = {2'b00, b_grant};
            obs_mem_read = b_mrd; obs_mem_write = b_mwr; obs_addr = b_addr; obs_wdata = b_wd;
        end else if (sel == 2) begin
            obs_rdata = c_rdata; obs_resp = c_resp; obs_grant = c_grant;
            obs_mem_read = c_mrd; obs_mem_write = c_mwr; obs_addr = c_addr; obs_wdata = c_wd;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LINE_W-1:0] pat(input logic [31:0] w);
        return {(LINE_W/32){w}};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [LINE_W-1:0] d);
        s_read[p]                 = rd;
        s_write[p]                = wr;
        s_addr[p*32 +: 32]        = a;
        s_wdata[p*LINE_W +: LINE_W] = d;
    endtask

    task automatic push_txn(input int p, input logic wr, input logic [31:0] a,
                            input logic [LINE_W-1:0] d);
        txn_t t;
        t.port = p; t.wr = wr; t.addr = a; t.wdata = d;
        sb.push_back(t);
    endtask

    // Pops the next expected transaction, waits for the adaptor request,
    // checks it through `lat` BUSY cycles while scrambling all request inputs,
    // answers with `rdata`, then checks the DONE cycle and drops `drop_mask`.
    task automatic serve(input int exp_wait, input int lat,
                         input logic [LINE_W-1:0] rdata, input logic [3:0] drop_mask);
        txn_t t;
        int waited;
        logic [3:0] exp_oh;
        logic [3:0] sv_read, sv_write;
        logic [127:0] sv_addr;
        logic [4*LINE_W-1:0] sv_wdata;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: queue empty, got 0 entries, required 1");
            return;
        end
        t = sb.pop_front();
        exp_oh = 4'b0001 << t.port;
        waited = 0;
        while (!(obs_mem_read || obs_mem_write) && waited < 20) begin
            step();
            waited++;
        end
        if (waited != exp_wait) begin
            miscompares++;
            $display("FAIL latency port%0d: got %0d cycles, required %0d", t.port, waited, exp_wait);
            if (waited >= 20) return;
        end
        vectors++;
        if (obs_grant !== exp_oh) begin
            miscompares++;
            $display("FAIL grant: got %b, required %b", obs_grant, exp_oh);
        end
        vectors++;
        if (obs_mem_write !== t.wr || obs_mem_read !== !t.wr) begin
            miscompares++;
            $display("FAIL op: got rd=%b wr=%b, required wr=%b", obs_mem_read, obs_mem_write, t.wr);
        end
        sv_read = s_read; sv_write = s_write; sv_addr = s_addr; sv_wdata = s_wdata;
        for (int c = 0; c < lat; c++) begin
            if (c > 0) step();
            s_read = ~sv_read; s_write = ~sv_write; s_addr = ~sv_addr; s_wdata = ~sv_wdata;
            vectors++;
            if (obs_addr !== t.addr || obs_resp !== 4'b0000 ||
                obs_mem_write !== t.wr || obs_mem_read !== !t.wr) begin
                miscompares++;
                $display("FAIL busy c%0d: got addr=%h resp=%b rd=%b wr=%b, required addr=%h resp=0000",
                         c, obs_addr, obs_resp, obs_mem_read, obs_mem_write, t.addr);
            end
            if (t.wr) begin
                vectors++;
                if (obs_wdata !== t.wdata) begin
                    miscompares++;
                    $display("FAIL wdata c%0d: got %h, required %h", c, obs_wdata[31:0], t.wdata[31:0]);
                end
            end
        end
        s_read = sv_read; s_write = sv_write; s_addr = sv_addr; s_wdata = sv_wdata;
        s_mem_rdata = rdata;
        s_mem_resp  = 1'b1;
        #1;
        vectors++;
        if (obs_resp !== exp_oh || obs_rdata !== rdata) begin
            miscompares++;
            $display("FAIL resp: got resp=%b rdata=%h, required resp=%b rdata=%h",
                     obs_resp, obs_rdata[31:0], exp_oh, rdata[31:0]);
        end
        step();
        // DONE cycle; mem_resp deliberately left high, it must be ignored here.
        vectors++;
        if (obs_mem_read !== 1'b0 || obs_mem_write !== 1'b0 ||
            obs_grant !== 4'b0000 || obs_resp !== 4'b0000) begin
            miscompares++;
            $display("FAIL done: got rd=%b wr=%b grant=%b resp=%b, required all zero",
                     obs_mem_read, obs_mem_write, obs_grant, obs_resp);
        end
        s_mem_resp = 1'b0;
        s_read  = s_read  & ~drop_mask;
        s_write = s_write & ~drop_mask;
    endtask

    task automatic check_idle(input string tag);
        vectors++;
        if (obs_grant !== 4'b0000 || obs_mem_read !== 1'b0 ||
            obs_mem_write !== 1'b0 || obs_resp !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s: got grant=%b rd=%b wr=%b resp=%b, required idle",
                     tag, obs_grant, obs_mem_read, obs_mem_write, obs_resp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_idle("reset_outputs");
            vectors++;
            if (obs_addr !== 32'h0 || obs_wdata !== '0) begin
                miscompares++;
                $display("FAIL reset_data inst%0d: got addr=%h, required 0", s, obs_addr);
            end
        end
        reset_n = 1'b1;
        sel = 0;
        step();
    endtask

    task automatic test_single_read();
        sel = 0;
        set_req(1, 1'b1, 1'b0, 32'h0000_1000, '0);
        push_txn(1, 1'b0, 32'h0000_1000, '0);
        serve(1, 5, pat(32'hA5A5_A5A5), 4'b0010);
        step();
        check_idle("single_after_done");
        step();
        check_idle("single_stays_idle");
    endtask

    task automatic test_rr_contention();
        sel = 0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, '0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0200, '0);
        for (int n = 0; n < 4; n++) begin
            push_txn(n % 2, 1'b0, (n % 2 == 0) ? 32'h100 : 32'h200, '0);
        end
        serve(1, 2, pat(32'h1111_0000), 4'b0000);
        serve(2, 3, pat(32'h1111_0001), 4'b0000);
        serve(2, 1, pat(32'h1111_0002), 4'b0000);
        serve(2, 2, pat(32'h1111_0003), 4'b0011);
        step();
        check_idle("rr_contention_end");
    endtask

    task automatic test_fixed_contention();
        sel = 1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, '0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0200, '0);
        for (int n = 0; n < 3; n++) push_txn(0, 1'b0, 32'h100, '0);
        push_txn(1, 1'b0, 32'h200, '0);
        serve(1, 2, pat(32'h2222_0000), 4'b0000);
        serve(2, 2, pat(32'h2222_0001), 4'b0000);
        serve(2, 2, pat(32'h2222_0002), 4'b0001);
        serve(2, 2, pat(32'h2222_0003), 4'b0010);
        step();
        check_idle("fixed_contention_end");
    endtask

    task automatic test_write_then_read();
        sel = 0;
        // Port 0 raises both read and write: a write must be issued.
        set_req(0, 1'b1, 1'b1, 32'h0000_0040, pat(32'hDEAD_BEEF));
        set_req(1, 1'b1, 1'b0, 32'h0000_0080, pat(32'h0BAD_F00D));
        push_txn(0, 1'b1, 32'h0000_0040, pat(32'hDEAD_BEEF));
        push_txn(1, 1'b0, 32'h0000_0080, '0);
        serve(1, 4, pat(32'h3333_0000), 4'b0001);
        serve(2, 3, pat(32'h3333_0001), 4'b0010);
        step();
        check_idle("write_read_end");
    endtask

    task automatic test_rr_wrap();
        sel = 2;
        set_req(2, 1'b1, 1'b0, 32'h0000_0300, '0);
        push_txn(2, 1'b0, 32'h300, '0);
        serve(1, 2, pat(32'h4444_0000), 4'b0100);       // rr_ptr -> 3
        step();
        set_req(0, 1'b1, 1'b0, 32'h0000_0010, '0);
        set_req(2, 1'b1, 1'b0, 32'h0000_0320, '0);
        push_txn(0, 1'b0, 32'h010, '0);                  // wraps past 3 to 0
        push_txn(2, 1'b0, 32'h320, '0);                  // rr_ptr 1 -> port 2
        serve(1, 2, pat(32'h4444_0001), 4'b0001);
        serve(2, 2, pat(32'h4444_0002), 4'b0100);       // rr_ptr -> 3
        step();
        set_req(1, 1'b1, 1'b0, 32'h0000_0110, '0);
        set_req(3, 1'b0, 1'b1, 32'h0000_0330, pat(32'h5A5A_0303));
        push_txn(3, 1'b1, 32'h330, pat(32'h5A5A_0303));
        push_txn(1, 1'b0, 32'h110, '0);
        serve(1, 1, pat(32'h4444_0003), 4'b1000);
        serve(2, 1, pat(32'h4444_0004), 4'b0010);
        step();
        check_idle("rr_wrap_end");
    endtask

    task automatic test_reset_mid_busy();
        sel = 0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0500, '0);
        push_txn(0, 1'b0, 32'h500, '0);
        serve(1, 1, pat(32'h6666_0000), 4'b0001);       // rr_ptr -> 1
        set_req(0, 1'b1, 1'b0, 32'h0000_0500, '0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0600, '0);
        step();                                          // IDLE
        step();                                          // BUSY, port 1 granted
        vectors++;
        if (obs_grant !== 4'b0010 || obs_mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_grant: got grant=%b rd=%b, required 0010/1", obs_grant, obs_mem_read);
        end
        step();
        step();
        s_mem_resp = 1'b1;
        reset_n    = 1'b0;
        #1;
        check_idle("reset_mid_busy");
        vectors++;
        if (obs_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_busy_addr: got %h, required 0", obs_addr);
        end
        s_mem_resp = 1'b0;
        step();
        reset_n = 1'b1;
        push_txn(0, 1'b0, 32'h500, '0);                  // rr_ptr restarts at 0
        push_txn(1, 1'b0, 32'h600, '0);
        serve(1, 2, pat(32'h6666_0001), 4'b0001);
        serve(2, 2, pat(32'h6666_0002), 4'b0010);
        step();
        check_idle("reset_mid_busy_end");
    endtask

    task automatic test_idle_resp();
        sel = 0;
        step();
        s_mem_resp = 1'b1;
        #1;
        check_idle("idle_resp_same_cycle");
        step();
        check_idle("idle_resp_next_cycle");
        s_mem_resp = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sel         = 0;
        reset_n     = 1'b0;
        s_read      = '0;
        s_write     = '0;
        s_addr      = '0;
        s_wdata     = '0;
        s_mem_resp  = 1'b0;
        s_mem_rdata = '0;
        test_reset();
        test_single_read();
        test_rr_contention();
        test_fixed_contention();
        test_write_then_read();
        test_rr_wrap();
        test_reset_mid_busy();
        test_idle_resp();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesting cache ports; legal range 2..8.
REQ-002 Parameter LINE_W, default 256: cache line width in bits.
REQ-003 Parameter ARB_MODE, default 1: 0 = fixed priority (port 0 highest), 1 = round-robin.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_read  in  NUM_PORTS  per-port line read request, level, held until that port's resp.
REQ-007 req_write  in  NUM_PORTS  per-port line write request, level, held until that port's resp.
REQ-008 req_addr  in  NUM_PORTS*32  per-port line address; port i occupies bits [32*i+31:32*i].
REQ-009 req_wdata  in  NUM_PORTS*LINE_W  per-port write line, sliced as for req_addr.
REQ-010 req_rdata  out  LINE_W  read line, broadcast to all ports.
REQ-011 req_resp  out  NUM_PORTS  per-port one-cycle completion pulse.
REQ-012 mem_read  out  1  read request to the cacheline adaptor.
REQ-013 mem_write  out  1  write request to the cacheline adaptor.
REQ-014 mem_address  out  32  line address to the adaptor.
REQ-015 mem_wdata  out  LINE_W  write line to the adaptor.
REQ-016 mem_rdata  in  LINE_W  read line from the adaptor.
REQ-017 mem_resp  in  1  adaptor completion pulse.
REQ-018 grant  out  NUM_PORTS  one-hot owner of the current transaction; all zero when idle.

Function
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE: a port is pending when req_read[i] or req_write[i] is 1; with none pending, stay in IDLE.
REQ-021 IDLE with any port pending: select a winner, register winner index, address, wdata and op, go to BUSY on the next edge.
REQ-022 Fixed mode: winner is the lowest pending index.
REQ-023 Round-robin mode: winner is the first pending index at or after rr_ptr, searching upward and wrapping modulo NUM_PORTS.
REQ-024 Port with both req_read and req_write high: the op is write.
REQ-025 BUSY: exactly one of mem_read/mem_write is 1, per the registered op; mem_address and mem_wdata come from registers, stable for the whole of BUSY.
REQ-026 Request changes on any port during BUSY have no effect on the mem_* outputs.
REQ-027 BUSY with mem_resp=1: req_resp[winner]=1 in that same cycle, req_rdata=mem_rdata combinationally, go to DONE.
REQ-028 req_resp bits other than winner stay 0 at all times; req_rdata is don't-care except when req_resp is asserted.
REQ-029 On leaving BUSY, round-robin mode sets rr_ptr=(winner+1) mod NUM_PORTS.
REQ-030 DONE: mem_read=mem_write=0 and grant=0 for one cycle (requester drop turnaround), then go to IDLE unconditionally.
REQ-031 Latency: request sampled in IDLE at cycle t gives mem_read/mem_write=1 at t+1; the next grant is no earlier than 2 cycles after mem_resp.
REQ-032 mem_resp while in IDLE or DONE: ignored, no req_resp generated.
REQ-033 grant is one-hot of winner throughout BUSY, zero otherwise.

Reset
REQ-034 reset_n=0 at any time, including mid-BUSY: immediately force state=IDLE, rr_ptr=0, winner=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, req_resp=0, grant=0.
REQ-035 A transaction interrupted by reset is dropped, with no resp; requesters re-arbitrate after reset_n rises.

Verification
REQ-036 Single read: port1 req_read, addr 0x0000_1000, mem_resp after 5 cycles with rdata 0xA5..A5 -> mem_read on cycle 1, address 0x1000, req_resp=2'b10 with rdata 0xA5..A5, then DONE, then IDLE.
REQ-037 Contention, ARB_MODE=1: ports 0 and 1 both hold read requests continuously -> grants alternate 0,1,0,1; each port gets req_resp exactly once per two transactions.
REQ-038 Contention, ARB_MODE=0: same stimulus -> port 0 wins every time; port 1 is served only after port 0 drops its request.
REQ-039 Write then read: port0 req_write, addr 0x40, wdata pattern 0xDEAD..., while port1 reads 0x80 -> mem_write with mem_wdata matching for the first transaction, then mem_read at 0x80; mem_address is stable during each BUSY.
REQ-040 NUM_PORTS=4, round-robin with rr_ptr=3 and ports 0 and 2 pending -> port 0 wins (wrap-around), then rr_ptr=1, then port 2 wins.
REQ-041 Reset mid-BUSY: assert reset_n=0 two cycles after grant -> mem_read=0 immediately, no req_resp; after release, a held request is re-granted starting from rr_ptr=0.
